// File: rtl/dispatch_ls.sv
// Load/store dispatch buffer: in-order FIFO between decode and the LS issue queue with CDB operand snooping.
// Optional DISPATCHLS_CDB_BYPASS_EN forwards a matching CDB broadcast combinationally onto the head outputs.
module dispatch_ls #(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic        dec_opcode,
    input  logic [15:0] dec_imm,
    input  logic [5:0]  dec_rdtag,
    input  logic [5:0]  dec_rstag,
    input  logic [5:0]  dec_rttag,
    input  logic [31:0] dec_rsdata,
    input  logic [31:0] dec_rtdata,
    input  logic        dec_rsvalid,
    input  logic        dec_rtvalid,
    input  logic        cdb_valid,
    input  logic [5:0]  cdb_tag,
    input  logic [31:0] cdb_data,
    output logic        dispatch_opcode,
    output logic [15:0] dispatch_imm,
    output logic [5:0]  dispatch_rdtag,
    output logic [5:0]  dispatch_rstag,
    output logic [5:0]  dispatch_rttag,
    output logic [31:0] dispatch_rsdata,
    output logic [31:0] dispatch_rtdata,
    output logic        dispatch_rsvalid,
    output logic        dispatch_rtvalid,
    output logic        dispatch_en,
    input  logic        dispatch_ready
);

    localparam logic [PTRW:0] FULL = (PTRW+1)'(DEPTH);
    localparam logic [PTRW:0] ONE  = (PTRW+1)'(1);

    logic [PTRW:0]   count_q, count_d;
    logic [PTRW-1:0] rdptr_q, wrptr_q;
    logic [DEPTH-1:0] vld_q, rsv_q, rtv_q;

    // Payload storage carries no reset; it is only visible while count_q != 0.
    logic        opcode_q [DEPTH];
    logic [15:0] imm_q    [DEPTH];
    logic [5:0]  rdtag_q  [DEPTH];
    logic [5:0]  rstag_q  [DEPTH];
    logic [5:0]  rttag_q  [DEPTH];
    logic [31:0] rsdata_q [DEPTH];
    logic [31:0] rtdata_q [DEPTH];

    logic push, pop, push_rs_hit, push_rt_hit;
    logic [DEPTH-1:0] rs_hit, rt_hit;

    assign dec_ready   = (count_q != FULL);
    assign dispatch_en = (count_q != '0);
    assign push        = dec_valid && dec_ready;
    assign pop         = dispatch_en && dispatch_ready;
    assign push_rs_hit = cdb_valid && !dec_rsvalid && (dec_rstag == cdb_tag);
    assign push_rt_hit = cdb_valid && !dec_rtvalid && (dec_rttag == cdb_tag);

    // The entry leaving this cycle is skipped; the issue queue sees that broadcast itself.
    always_comb begin
        rs_hit = '0;
        rt_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cdb_valid && vld_q[i] && !(pop && rdptr_q == PTRW'(i))) begin
                rs_hit[i] = !rsv_q[i] && (rstag_q[i] == cdb_tag);
                rt_hit[i] = !rtv_q[i] && (rttag_q[i] == cdb_tag);
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            rdptr_q <= '0;
            wrptr_q <= '0;
            vld_q   <= '0;
            rsv_q   <= '0;
            rtv_q   <= '0;
        end else if (flush) begin
            count_q <= '0;
            rdptr_q <= '0;
            wrptr_q <= '0;
            vld_q   <= '0;
            rsv_q   <= '0;
            rtv_q   <= '0;
        end else begin
            count_q <= count_d;
            rsv_q   <= rsv_q | rs_hit;
            rtv_q   <= rtv_q | rt_hit;
            if (pop) begin
                vld_q[rdptr_q] <= 1'b0;
                rdptr_q        <= rdptr_q + 1'b1;
            end
            if (push) begin
                vld_q[wrptr_q] <= 1'b1;
                rsv_q[wrptr_q] <= dec_rsvalid || push_rs_hit;
                rtv_q[wrptr_q] <= dec_rtvalid || push_rt_hit;
                wrptr_q        <= wrptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rs_hit[i]) rsdata_q[i] <= cdb_data;
                if (rt_hit[i]) rtdata_q[i] <= cdb_data;
            end
            if (push) begin
                opcode_q[wrptr_q] <= dec_opcode;
                imm_q[wrptr_q]    <= dec_imm;
                rdtag_q[wrptr_q]  <= dec_rdtag;
                rstag_q[wrptr_q]  <= dec_rstag;
                rttag_q[wrptr_q]  <= dec_rttag;
                rsdata_q[wrptr_q] <= push_rs_hit ? cdb_data : dec_rsdata;
                rtdata_q[wrptr_q] <= push_rt_hit ? cdb_data : dec_rtdata;
            end
        end
    end

    logic        head_rsv, head_rtv;
    logic [31:0] head_rsd, head_rtd;

    always_comb begin
        head_rsv = rsv_q[rdptr_q];
        head_rtv = rtv_q[rdptr_q];
        head_rsd = rsdata_q[rdptr_q];
        head_rtd = rtdata_q[rdptr_q];
`ifdef DISPATCHLS_CDB_BYPASS_EN
        if (cdb_valid && !rsv_q[rdptr_q] && (rstag_q[rdptr_q] == cdb_tag)) begin
            head_rsv = 1'b1;
            head_rsd = cdb_data;
        end
        if (cdb_valid && !rtv_q[rdptr_q] && (rttag_q[rdptr_q] == cdb_tag)) begin
            head_rtv = 1'b1;
            head_rtd = cdb_data;
        end
`endif
    end

    assign dispatch_opcode  = dispatch_en && opcode_q[rdptr_q];
    assign dispatch_imm     = dispatch_en ? imm_q[rdptr_q]   : '0;
    assign dispatch_rdtag   = dispatch_en ? rdtag_q[rdptr_q] : '0;
    assign dispatch_rstag   = dispatch_en ? rstag_q[rdptr_q] : '0;
    assign dispatch_rttag   = dispatch_en ? rttag_q[rdptr_q] : '0;
    assign dispatch_rsdata  = dispatch_en ? head_rsd : '0;
    assign dispatch_rtdata  = dispatch_en ? head_rtd : '0;
    assign dispatch_rsvalid = dispatch_en && head_rsv;
    assign dispatch_rtvalid = dispatch_en && head_rtv;

endmodule

// File: tb/tb_dispatch_ls.sv
// Bench for dispatch_ls: directed steps plus random traffic against a queue-based reference model.
module tb_dispatch_ls;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        dec_valid = 1'b0;
    logic        dec_ready;
    logic        dec_opcode = 1'b0;
    logic [15:0] dec_imm = '0;
    logic [5:0]  dec_rdtag = '0, dec_rstag = '0, dec_rttag = '0;
    logic [31:0] dec_rsdata = '0, dec_rtdata = '0;
    logic        dec_rsvalid = 1'b0, dec_rtvalid = 1'b0;
    logic        cdb_valid = 1'b0;
    logic [5:0]  cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic        dispatch_opcode;
    logic [15:0] dispatch_imm;
    logic [5:0]  dispatch_rdtag, dispatch_rstag, dispatch_rttag;
    logic [31:0] dispatch_rsdata, dispatch_rtdata;
    logic        dispatch_rsvalid, dispatch_rtvalid, dispatch_en;
    logic        dispatch_ready = 1'b0;

    dispatch_ls #(.DEPTH(DEPTH), .PTRW(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
        .dec_imm(dec_imm), .dec_rdtag(dec_rdtag), .dec_rstag(dec_rstag), .dec_rttag(dec_rttag),
        .dec_rsdata(dec_rsdata), .dec_rtdata(dec_rtdata),
        .dec_rsvalid(dec_rsvalid), .dec_rtvalid(dec_rtvalid),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .dispatch_opcode(dispatch_opcode), .dispatch_imm(dispatch_imm),
        .dispatch_rdtag(dispatch_rdtag), .dispatch_rstag(dispatch_rstag),
        .dispatch_rttag(dispatch_rttag), .dispatch_rsdata(dispatch_rsdata),
        .dispatch_rtdata(dispatch_rtdata), .dispatch_rsvalid(dispatch_rsvalid),
        .dispatch_rtvalid(dispatch_rtvalid), .dispatch_en(dispatch_en),
        .dispatch_ready(dispatch_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [15:0] imm;
        logic [5:0]  rd, rs, rt;
        logic [31:0] rsd, rtd;
        logic        rsv, rtv;
    } ent_t;

    ent_t mq[$];
    int compared = 0;
    int mism = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic ent_t snoop(input ent_t e);
        ent_t r = e;
        if (cdb_valid) begin
            if (!r.rsv && r.rs == cdb_tag) begin r.rsv = 1'b1; r.rsd = cdb_data; end
            if (!r.rtv && r.rt == cdb_tag) begin r.rtv = 1'b1; r.rtd = cdb_data; end
        end
        return r;
    endfunction

    function automatic logic [100:0] pack(input ent_t e);
        return {e.op, e.imm, e.rd, e.rs, e.rt, e.rsd, e.rtd, e.rsv, e.rtv};
    endfunction

    task automatic check_model(input string tag);
        ent_t h;
        logic [100:0] expb, obsb;
        obsb = {dispatch_opcode, dispatch_imm, dispatch_rdtag, dispatch_rstag, dispatch_rttag,
                dispatch_rsdata, dispatch_rtdata, dispatch_rsvalid, dispatch_rtvalid};
        expb = '0;
        if (mq.size() > 0) begin
            h = mq[0];
`ifdef DISPATCHLS_CDB_BYPASS_EN
            h = snoop(h);
`endif
            expb = pack(h);
        end
        chk({tag, "_en"}, dispatch_en, mq.size() > 0);
        chk({tag, "_dec_ready"}, dec_ready, mq.size() < DEPTH);
        chk({tag, "_bundle"}, obsb, expb);
    endtask

    // Called right after a negedge with inputs already driven; returns at the next negedge.
    task automatic tick(input string tag);
        ent_t nq[$];
        ent_t e;
        bit pop, push;
        #1;
        check_model(tag);
        nq = mq;
        if (flush) nq.delete();
        else begin
            pop  = (nq.size() > 0) && dispatch_ready;
            push = dec_valid && (mq.size() < DEPTH);
            for (int k = (pop ? 1 : 0); k < nq.size(); k++) nq[k] = snoop(nq[k]);
            if (pop) void'(nq.pop_front());
            if (push) begin
                e.op = dec_opcode; e.imm = dec_imm; e.rd = dec_rdtag; e.rs = dec_rstag;
                e.rt = dec_rttag; e.rsd = dec_rsdata; e.rtd = dec_rtdata;
                e.rsv = dec_rsvalid; e.rtv = dec_rtvalid;
                nq.push_back(snoop(e));
            end
        end
        @(posedge clk);
        mq = nq;
        @(negedge clk);
    endtask

    task automatic set_op(input logic op, input logic [15:0] imm, input logic [5:0] rd,
                          input logic [5:0] rs, input logic [5:0] rt, input logic [31:0] rsd,
                          input logic [31:0] rtd, input logic rsv, input logic rtv);
        dec_valid = 1'b1; dec_opcode = op; dec_imm = imm; dec_rdtag = rd;
        dec_rstag = rs; dec_rttag = rt; dec_rsdata = rsd; dec_rtdata = rtd;
        dec_rsvalid = rsv; dec_rtvalid = rtv;
    endtask

    initial begin
        // Reset and idle
        @(negedge clk);
        #1;
        chk("reset_en", dispatch_en, 1'b0);
        chk("reset_dec_ready", dec_ready, 1'b1);
        chk("reset_imm", dispatch_imm, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        tick("idle");

        // Single load, dispatched immediately
        dispatch_ready = 1'b1;
        set_op(1'b0, 16'h0010, 6'd5, 6'd3, 6'd20, 32'h1000, 32'h0, 1'b1, 1'b1);
        tick("push_load");
        dec_valid = 1'b0;
        chk("load_en", dispatch_en, 1'b1);
        chk("load_imm", dispatch_imm, 16'h0010);
        chk("load_rdtag", dispatch_rdtag, 6'd5);
        chk("load_rstag", dispatch_rstag, 6'd3);
        chk("load_rsdata", dispatch_rsdata, 32'h1000);
        chk("load_rsvalid", dispatch_rsvalid, 1'b1);
        tick("load_pop");
        chk("load_gone_en", dispatch_en, 1'b0);

        // Fill past capacity, then drain in order across the pointer wrap
        dispatch_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            set_op(i[0], 16'(i), 6'(i), 6'd40, 6'd41, 32'(i * 3), 32'(i * 7), 1'b1, 1'b1);
            if (i == 5) chk("full_dec_ready", dec_ready, 1'b0);
            tick("fill");
        end
        dec_valid = 1'b0;
        dispatch_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order_imm", dispatch_imm, 16'(i));
            tick("drain");
            if (i == 1) chk("drain_dec_ready", dec_ready, 1'b1);
        end
        chk("drain_empty", dispatch_en, 1'b0);

        // CDB wakes up a buffered rt operand
        dispatch_ready = 1'b0;
        set_op(1'b1, 16'h0abc, 6'd11, 6'd12, 6'd9, 32'h1, 32'h0, 1'b1, 1'b0);
        tick("rt_push");
        dec_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'hDEADBEEF;
        #1;
`ifdef DISPATCHLS_CDB_BYPASS_EN
        chk("bypass_rtvalid", dispatch_rtvalid, 1'b1);
        chk("bypass_rtdata", dispatch_rtdata, 32'hDEADBEEF);
`else
        chk("nobypass_rtvalid", dispatch_rtvalid, 1'b0);
`endif
        tick("rt_cdb");
        cdb_valid = 1'b0;
        chk("snoop_rtvalid", dispatch_rtvalid, 1'b1);
        chk("snoop_rtdata", dispatch_rtdata, 32'hDEADBEEF);
        dispatch_ready = 1'b1;
        tick("rt_drain");

        // Operand captured from the CDB in the push cycle itself
        dispatch_ready = 1'b0;
        set_op(1'b0, 16'h0007, 6'd1, 6'd7, 6'd2, 32'h0, 32'h2, 1'b0, 1'b1);
        cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_data = 32'h55;
        tick("push_cdb");
        dec_valid = 1'b0; cdb_valid = 1'b0;
        chk("push_cdb_rsvalid", dispatch_rsvalid, 1'b1);
        chk("push_cdb_rsdata", dispatch_rsdata, 32'h55);
        dispatch_ready = 1'b1;
        tick("push_cdb_drain");

        // Flush with a concurrent push
        dispatch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op(1'b0, 16'(16'h100 + i), 6'(i), 6'd30, 6'd31, 32'h0, 32'h0, 1'b1, 1'b1);
            tick("pre_flush");
        end
        set_op(1'b1, 16'h0bad, 6'd33, 6'd34, 6'd35, 32'h0, 32'h0, 1'b1, 1'b1);
        flush = 1'b1;
        tick("flush");
        flush = 1'b0; dec_valid = 1'b0;
        chk("flush_en", dispatch_en, 1'b0);
        chk("flush_dec_ready", dec_ready, 1'b1);
        tick("post_flush");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            dec_valid = 1'($urandom_range(0, 1));
            dec_opcode = 1'($urandom_range(0, 1));
            dec_imm = 16'($urandom);
            dec_rdtag = 6'($urandom_range(0, 63));
            dec_rstag = 6'($urandom_range(0, 7));
            dec_rttag = 6'($urandom_range(0, 7));
            dec_rsdata = $urandom;
            dec_rtdata = $urandom;
            dec_rsvalid = 1'($urandom_range(0, 1));
            dec_rtvalid = 1'($urandom_range(0, 1));
            cdb_valid = 1'($urandom_range(0, 1));
            cdb_tag = 6'($urandom_range(0, 7));
            cdb_data = $urandom;
            dispatch_ready = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 40) == 0);
            tick("rand");
        end
        flush = 1'b0; cdb_valid = 1'b0;

        // Asynchronous reset mid-stream
        dispatch_ready = 1'b0;
        set_op(1'b1, 16'h0f0f, 6'd3, 6'd4, 6'd5, 32'h9, 32'h8, 1'b1, 1'b1);
        tick("pre_areset");
        tick("pre_areset");
        dec_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("areset_en", dispatch_en, 1'b0);
        chk("areset_imm", dispatch_imm, 16'h0);
        chk("areset_dec_ready", dec_ready, 1'b1);
        mq.delete();
        @(negedge clk);
        reset = 1'b0;
        tick("post_areset");
        tick("post_areset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
